// File: rtl/motor_timer_fsm_pkg.sv
// Shared state codes, select limits and BCD helpers for the motor timer.
// Also used by motor_time_control for the select range.
package motor_timer_fsm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_DONE  = 3'd3
  } state_t;

  localparam logic [2:0] SEL_OFF = 3'd0;
  localparam logic [2:0] SEL_MAX = 3'd4;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] units;
  } bcd_t;

  // Add to the tens digit; anything past 9x saturates to 99.
  function automatic bcd_t bcd_add_tens(
    input bcd_t       t,
    input logic [3:0] step
  );
    bcd_t       r;
    logic [4:0] sum;
    sum = {1'b0, t.tens} + {1'b0, step};
    r   = t;
    if (sum > 5'd9) begin
      r.tens  = 4'd9;
      r.units = 4'd9;
    end else begin
      r.tens = sum[3:0];
    end
    return r;
  endfunction

  function automatic bcd_t bcd_dec(input bcd_t t);
    bcd_t r;
    r = t;
    if (t.units != 4'd0) begin
      r.units = t.units - 4'd1;
    end else if (t.tens != 4'd0) begin
      r.units = 4'd9;
      r.tens  = t.tens - 4'd1;
    end
    return r;
  endfunction

  function automatic logic [2:0] sel_next(input logic [2:0] s);
    return (s >= SEL_MAX) ? 3'd1 : s + 3'd1;
  endfunction

endpackage

// File: rtl/motor_timer_fsm_tick_gen.sv
// One-second prescaler: pulses o_tick on the last count of TICK_DIV.
// Holds its count while disabled so a paused run resumes mid-second.
module tick_gen #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int W = $clog2(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt;

  assign o_tick = i_en && (cnt == LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (i_clr) begin
      cnt <= '0;
    end else if (i_en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/motor_timer_fsm.sv
// Run/pause sequencer with BCD countdown and speed select for the
// motor panel; all outputs are registered.
module motor_timer_fsm
  import motor_timer_fsm_pkg::*;
#(
  parameter int TICK_DIV  = 100_000_000,
  parameter int TIME_STEP = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_btn_speed,
  input  logic       i_btn_time,
  input  logic       i_btn_start,
  input  logic       i_btn_stop,
  output logic [3:0] o_sec_10,
  output logic [3:0] o_sec_1,
  output logic [2:0] o_select,
  output logic [2:0] o_state,
  output logic       o_running,
  output logic       o_done
);

  localparam logic [3:0] STEP = 4'(TIME_STEP);

  state_t     state_q, state_d;
  bcd_t       time_q, time_d, t;
  logic [2:0] sel_q, sel_d;
  logic       run_q, done_q, done_d;
  logic       tick, tick_en, tick_clr;
  logic       time_nz;

  assign time_nz = (time_q != '0);

  // A start/stop edge in RUN freezes the prescaler so PAUSE keeps the phase.
  assign tick_en = (state_q == ST_RUN) && !i_btn_start && !i_btn_stop;
  assign tick_clr = (state_q == ST_IDLE) && !i_btn_stop && i_btn_start
                 && time_nz && (sel_q != SEL_OFF);

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (tick_en),
    .i_clr   (tick_clr),
    .o_tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    sel_d   = sel_q;
    done_d  = 1'b0;
    t       = time_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_btn_stop) begin
          time_d = '0;
          sel_d  = SEL_OFF;
        end else if (i_btn_start) begin
          if (tick_clr) state_d = ST_RUN;
        end else if (i_btn_time) begin
          time_d = bcd_add_tens(time_q, STEP);
        end else if (i_btn_speed) begin
          sel_d = sel_next(sel_q);
        end
      end
      ST_RUN: begin
        if (i_btn_stop) begin
          state_d = ST_IDLE;
          time_d  = '0;
          sel_d   = SEL_OFF;
        end else if (i_btn_start) begin
          state_d = ST_PAUSE;
        end else begin
          if (i_btn_time) t = bcd_add_tens(t, STEP);
          else if (i_btn_speed) sel_d = sel_next(sel_q);
          if (tick) t = bcd_dec(t);
          time_d = t;
          if (tick && t == '0) begin
            state_d = ST_DONE;
            sel_d   = SEL_OFF;
            done_d  = 1'b1;
          end
        end
      end
      ST_PAUSE: begin
        if (i_btn_stop) begin
          state_d = ST_IDLE;
          time_d  = '0;
          sel_d   = SEL_OFF;
        end else if (i_btn_start) begin
          state_d = ST_RUN;
        end else if (i_btn_time) begin
          time_d = bcd_add_tens(time_q, STEP);
        end else if (i_btn_speed) begin
          sel_d = sel_next(sel_q);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        time_d  = '0;
        sel_d   = SEL_OFF;
      end
      default: begin
        state_d = ST_IDLE;
        time_d  = '0;
        sel_d   = SEL_OFF;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      time_q  <= '0;
      sel_q   <= SEL_OFF;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      sel_q   <= sel_d;
      run_q   <= (state_d == ST_RUN);
      done_q  <= done_d;
    end
  end

  assign o_sec_10  = time_q.tens;
  assign o_sec_1   = time_q.units;
  assign o_select  = sel_q;
  assign o_state   = state_q;
  assign o_running = run_q;
  assign o_done    = done_q;

endmodule

// File: tb/tb_motor_timer_fsm.sv
// Directed bench for motor_timer_fsm with TICK_DIV=4: a vector table
// for single-cycle button behaviour plus multi-cycle sequences.
module tb_motor_timer_fsm;

  localparam logic [3:0] B_NONE = 4'b0000;
  localparam logic [3:0] B_SPD  = 4'b1000;
  localparam logic [3:0] B_TIM  = 4'b0100;
  localparam logic [3:0] B_STA  = 4'b0010;
  localparam logic [3:0] B_STP  = 4'b0001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_speed = 1'b0;
  logic       btn_time = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_stop = 1'b0;
  logic [3:0] sec_10, sec_1;
  logic [2:0] sel, state;
  logic       running, done;

  int tests = 0;
  int fails = 0;
  int done_seen = 0;

  typedef struct {
    logic [3:0] btn;
    int tens, units, sel, st, run, done;
  } vec_t;

  vec_t tbl[13];

  motor_timer_fsm #(
    .TICK_DIV  (4),
    .TIME_STEP (1)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_btn_speed (btn_speed),
    .i_btn_time  (btn_time),
    .i_btn_start (btn_start),
    .i_btn_stop  (btn_stop),
    .o_sec_10    (sec_10),
    .o_sec_1     (sec_1),
    .o_select    (sel),
    .o_state     (state),
    .o_running   (running),
    .o_done      (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_seen <= done_seen + 1;

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_all(input string name, input int tn, input int un,
                         input int sl, input int st, input int rn,
                         input int dn);
    chk({name, ".time"}, int'(sec_10) * 10 + int'(sec_1), tn * 10 + un);
    chk({name, ".sel"}, int'(sel), sl);
    chk({name, ".state"}, int'(state), st);
    chk({name, ".run"}, int'(running), rn);
    chk({name, ".done"}, int'(done), dn);
  endtask

  task automatic press(input logic [3:0] b);
    {btn_speed, btn_time, btn_start, btn_stop} = b;
    @(posedge clk);
    #1;
    {btn_speed, btn_time, btn_start, btn_stop} = B_NONE;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = '{B_NONE, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{B_TIM, 1, 0, 0, 0, 0, 0};
    tbl[2]  = '{B_STA, 1, 0, 0, 0, 0, 0};
    tbl[3]  = '{B_STP, 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{B_SPD, 0, 0, 1, 0, 0, 0};
    tbl[5]  = '{B_SPD, 0, 0, 2, 0, 0, 0};
    tbl[6]  = '{B_SPD, 0, 0, 3, 0, 0, 0};
    tbl[7]  = '{B_STA, 0, 0, 3, 0, 0, 0};
    tbl[8]  = '{B_SPD, 0, 0, 4, 0, 0, 0};
    tbl[9]  = '{B_SPD, 0, 0, 1, 0, 0, 0};
    tbl[10] = '{B_STA | B_TIM | B_SPD, 0, 0, 1, 0, 0, 0};
    tbl[11] = '{B_TIM | B_SPD, 1, 0, 1, 0, 0, 0};
    tbl[12] = '{B_STP | B_TIM, 0, 0, 0, 0, 0, 0};

    #3;
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 13; i++) begin
      press(tbl[i].btn);
      chk_all($sformatf("vec%0d", i), tbl[i].tens, tbl[i].units,
              tbl[i].sel, tbl[i].st, tbl[i].run, tbl[i].done);
    end

    // Full countdown from 10 s.
    do_reset();
    press(B_SPD);
    press(B_SPD);
    press(B_TIM);
    press(B_STA);
    chk_all("t1.start", 1, 0, 2, 1, 1, 0);
    idle(3);
    chk_all("t1.cyc3", 1, 0, 2, 1, 1, 0);
    idle(1);
    chk_all("t1.cyc4", 0, 9, 2, 1, 1, 0);
    idle(35);
    chk_all("t1.cyc39", 0, 1, 2, 1, 1, 0);
    idle(1);
    chk_all("t1.done", 0, 0, 0, 3, 0, 1);
    idle(1);
    chk_all("t1.idle", 0, 0, 0, 0, 0, 0);
    chk("t1.done_cnt", done_seen, 1);

    // Pause keeps the prescaler phase.
    do_reset();
    press(B_SPD);
    press(B_TIM);
    press(B_TIM);
    press(B_STA);
    idle(32);
    chk_all("t3.at12", 1, 2, 1, 1, 1, 0);
    idle(2);
    press(B_STA);
    chk_all("t3.pause", 1, 2, 1, 2, 0, 0);
    idle(20);
    chk_all("t3.hold", 1, 2, 1, 2, 0, 0);
    press(B_STA);
    chk_all("t3.resume", 1, 2, 1, 1, 1, 0);
    idle(1);
    chk_all("t3.res1", 1, 2, 1, 1, 1, 0);
    idle(1);
    chk_all("t3.res2", 1, 1, 1, 1, 1, 0);

    // Time saturation and time press coincident with a tick.
    do_reset();
    repeat (9) press(B_TIM);
    chk_all("t4.90", 9, 0, 0, 0, 0, 0);
    repeat (3) press(B_TIM);
    chk_all("t4.99", 9, 9, 0, 0, 0, 0);
    do_reset();
    press(B_SPD);
    press(B_TIM);
    press(B_STA);
    idle(23);
    chk_all("t4.at05", 0, 5, 1, 1, 1, 0);
    press(B_TIM);
    chk_all("t4.14", 1, 4, 1, 1, 1, 0);

    // Select wrap in RUN, then stop beats start and speed.
    do_reset();
    repeat (4) press(B_SPD);
    press(B_TIM);
    press(B_STA);
    press(B_SPD);
    chk_all("t5.wrap", 1, 0, 1, 1, 1, 0);
    press(B_STP | B_STA | B_SPD);
    chk_all("t5.stop", 0, 0, 0, 0, 0, 0);
    idle(6);
    chk_all("t5.after", 0, 0, 0, 0, 0, 0);
    chk("t5.done_cnt", done_seen, 1);

    // Asynchronous reset mid-run at 37.
    do_reset();
    press(B_SPD);
    repeat (4) press(B_TIM);
    press(B_STA);
    idle(12);
    chk_all("t6.at37", 3, 7, 1, 1, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("t6.async", 0, 0, 0, 0, 0, 0);
    idle(3);
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);
    chk_all("t6.post", 0, 0, 0, 0, 0, 0);
    chk("t6.done_cnt", done_seen, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
